// File: rtl/p2s_pkg.sv
// Shared types and frame-geometry helpers for the parallel-to-serial transmitter.
// Optional build macro PARALLEL_TO_SERIAL_PARITY_EN appends an even-parity bit to each frame.
package p2s_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int frame_len(input int data_w);
    return PARITY_EN ? (data_w + 32'sd1) : data_w;
  endfunction

  function automatic int cnt_width(input int data_w);
    return (frame_len(data_w) > 32'sd1) ? $clog2(frame_len(data_w)) : 32'sd1;
  endfunction

endpackage

// File: rtl/p2s_hold_buf.sv
// One-entry valid/ready holding register feeding the shifter.
// Build macro PARALLEL_TO_SERIAL_PARITY_EN does not affect this block.
module p2s_hold_buf
  import p2s_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] hold_data,
  output logic              hold_valid
);

  logic accept_s;

  // A pop in the same cycle frees the slot, so a refill can coincide with it.
  assign in_ready = !hold_valid || pop;
  assign accept_s = in_valid && in_ready;

  // Holding register: refill on accept, otherwise drain on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      hold_valid <= 1'b1;
      hold_data  <= in_data;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// Serialiser: words from a one-entry buffer are shifted out one bit per clk with framing pulses.
// Build macro PARALLEL_TO_SERIAL_PARITY_EN adds a trailing even-parity bit (PARITY state).
module parallel_to_serial
  import p2s_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_out,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] PEN_DATA  = CNT_W'(DATA_W - 2);

  state_e             state_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [DATA_W-1:0]  shift_reg_r;
  logic [DATA_W-1:0]  hold_data_s;
  logic               hold_valid_s;
  logic               load_s;
  logic               last_bit_s;
  logic               next_bit_s;
  logic [DATA_W-1:0]  shifted_s;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  logic               parity_r;

  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  p2s_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pop        (load_s),
    .hold_data  (hold_data_s),
    .hold_valid (hold_valid_s)
  );

  // shift_reg keeps the bit currently on the line at its leading end.
  assign next_bit_s = MSB_FIRST ? shift_reg_r[DATA_W-2] : shift_reg_r[1];
  assign shifted_s  = MSB_FIRST ? {shift_reg_r[DATA_W-2:0], 1'b0}
                                : {1'b0, shift_reg_r[DATA_W-1:1]};
  assign busy       = (state_r != IDLE) || hold_valid_s;

  // Detect the final bit of the frame now on the line, enabling a gap-free reload.
  always_comb begin
    last_bit_s = 1'b0;
    case (state_r)
      SHIFT:   last_bit_s = !PARITY_EN && (bit_cnt_r == LAST_DATA);
      PARITY:  last_bit_s = PARITY_EN;
      default: last_bit_s = 1'b0;
    endcase
    load_s = hold_valid_s && ((state_r == IDLE) || last_bit_s);
  end

  // Shifter FSM; serial_out and the framing flags are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= {CNT_W{1'b0}};
      shift_reg_r <= {DATA_W{1'b0}};
      serial_out  <= IDLE_LEVEL;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else if (load_s) begin
      state_r     <= SHIFT;
      bit_cnt_r   <= {CNT_W{1'b0}};
      shift_reg_r <= hold_data_s;
      serial_out  <= first_bit(hold_data_s);
      frame_start <= 1'b1;
      frame_end   <= 1'b0;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
      parity_r    <= even_parity(hold_data_s);
`endif
    end else begin
      case (state_r)
        SHIFT: begin
          if (bit_cnt_r == LAST_DATA) begin
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
            state_r     <= PARITY;
            bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
            serial_out  <= parity_r;
            frame_start <= 1'b0;
            frame_end   <= 1'b1;
`else
            state_r     <= IDLE;
            bit_cnt_r   <= {CNT_W{1'b0}};
            serial_out  <= IDLE_LEVEL;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
`endif
          end else begin
            bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
            shift_reg_r <= shifted_s;
            serial_out  <= next_bit_s;
            frame_start <= 1'b0;
            frame_end   <= !PARITY_EN && (bit_cnt_r == PEN_DATA);
          end
        end
        default: begin
          state_r     <= IDLE;
          bit_cnt_r   <= {CNT_W{1'b0}};
          serial_out  <= IDLE_LEVEL;
          frame_start <= 1'b0;
          frame_end   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: vector table, hand-written corner sequences and a bit-level scoreboard.
// Build with PARALLEL_TO_SERIAL_PARITY_EN to exercise the parity frame.
module tb_parallel_to_serial;

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  typedef struct packed {
    logic b;
    logic fs;
    logic fe;
  } sb_t;

  typedef struct {
    logic [7:0] word;
    logic       lsb;   // 1 = drive the LSB-first instance
    logic [8:0] exp;   // transmit order, first bit in [8], parity in [0]
  } tvec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data, in_data_l;
  logic       in_valid, in_valid_l;
  logic       in_ready, in_ready_l;
  logic       serial_out, serial_out_l;
  logic       frame_start, frame_start_l;
  logic       frame_end, frame_end_l;
  logic       busy, busy_l;

  int  errors = 0;
  int  checks = 0;
  sb_t sb_q[$];
  logic in_frame = 1'b0;

  always #5 clk = ~clk;

  parallel_to_serial #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .serial_out(serial_out), .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
  );

  parallel_to_serial #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data_l), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .serial_out(serial_out_l), .frame_start(frame_start_l), .frame_end(frame_end_l), .busy(busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame for the MSB-first instance, built from the word itself.
  task automatic push_word(input logic [7:0] w);
    sb_t e;
    for (int i = 0; i < FL; i++) begin
      e.b  = (i < 8) ? w[7-i] : ^w;
      e.fs = (i == 0);
      e.fe = (i == FL - 1);
      sb_q.push_back(e);
    end
  endtask

  // Scoreboard monitor on the MSB-first instance, sampled mid-cycle.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      sb_q.delete();
      in_frame = 1'b0;
    end else if (in_frame || frame_start) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
        in_frame = 1'b0;
      end else begin
        e = sb_q.pop_front();
        chk("sb_bit", {29'd0, serial_out, frame_start, frame_end}, {29'd0, e.b, e.fs, e.fe});
        in_frame = !e.fe;
      end
    end else begin
      chk("sb_idle", {30'd0, serial_out, frame_end}, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tvec_t tv[4];
    logic [17:0] b2b_exp;
    logic so, fs, fe, bz;

    tv[0] = '{word: 8'hA5, lsb: 1'b0, exp: 9'b101001010};
    tv[1] = '{word: 8'h03, lsb: 1'b1, exp: 9'b110000000};
    tv[2] = '{word: 8'h07, lsb: 1'b0, exp: 9'b000001111};
    tv[3] = '{word: 8'h5A, lsb: 1'b1, exp: 9'b010110100};
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
    b2b_exp = 18'b000000011_100000001;
`else
    b2b_exp = {16'b00000001_10000000, 2'b00};
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_valid_l = 1'b0; in_data_l = 8'h00;

    // Reset held for three edges, then idle.
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_serial", serial_out, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_flags", {frame_start, frame_end}, 2'b00);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_serial", {serial_out, serial_out_l}, 2'b00);
      chk("idle_busy", {busy, busy_l}, 2'b00);
      chk("idle_ready", {in_ready, in_ready_l}, 2'b11);
      tick();
    end

    // Table-driven single words.
    for (int v = 0; v < 4; v++) begin
      if (tv[v].lsb) begin
        in_data_l = tv[v].word; in_valid_l = 1'b1;
        chk("tv_ready", in_ready_l, 1'b1);
      end else begin
        in_data = tv[v].word; in_valid = 1'b1;
        chk("tv_ready", in_ready, 1'b1);
        push_word(tv[v].word);
      end
      tick();
      in_valid = 1'b0; in_valid_l = 1'b0;
      for (int j = 0; j < FL; j++) begin
        tick();
        so = tv[v].lsb ? serial_out_l  : serial_out;
        fs = tv[v].lsb ? frame_start_l : frame_start;
        fe = tv[v].lsb ? frame_end_l   : frame_end;
        bz = tv[v].lsb ? busy_l        : busy;
        chk("tv_bit", so, tv[v].exp[8-j]);
        chk("tv_fstart", fs, (j == 0));
        chk("tv_fend", fe, (j == FL - 1));
        chk("tv_busy", bz, 1'b1);
      end
      tick();
      chk("tv_done_serial", tv[v].lsb ? serial_out_l : serial_out, 1'b0);
      chk("tv_done_busy", tv[v].lsb ? busy_l : busy, 1'b0);
    end

    // Back-to-back 01 then 80 with in_valid held high.
    in_data = 8'h01; in_valid = 1'b1;
    chk("b2b_ready0", in_ready, 1'b1);
    push_word(8'h01);
    tick();
    in_data = 8'h80;
    chk("b2b_ready1", in_ready, 1'b1);
    push_word(8'h80);
    tick();
    in_data = 8'h3C;
    for (int j = 0; j < 2 * FL; j++) begin
      chk("b2b_bit", serial_out, b2b_exp[17-j]);
      chk("b2b_fstart", frame_start, (j == 0) || (j == FL));
      chk("b2b_fend", frame_end, (j == FL - 1) || (j == 2 * FL - 1));
      if (j < FL - 1) begin
        chk("b2b_stall", in_ready, 1'b0);
      end else if (j == FL - 1) begin
        chk("b2b_reopen", in_ready, 1'b1);
        in_valid = 1'b0;
      end
      tick();
    end
    chk("b2b_done_busy", busy, 1'b0);

    // Mid-word reset drops the rest of the word.
    in_data = 8'hFF; in_valid = 1'b1;
    push_word(8'hFF);
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) tick();
    chk("mwr_bit", serial_out, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mwr_serial", serial_out, 1'b0);
    chk("mwr_busy", busy, 1'b0);
    chk("mwr_ready", in_ready, 1'b1);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("mwr_quiet", {serial_out, frame_start, busy}, 3'b000);
    end

    // Random words with random gaps, checked by the scoreboard.
    for (int n = 0; n < 8; n++) begin
      int t;
      in_data = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 40) begin
        tick();
        t++;
      end
      chk("rand_ready", in_ready, 1'b1);
      if (in_ready) push_word(in_data);
      tick();
      in_valid = 1'b0;
      for (int g = 0; g < $urandom_range(0, 3); g++) tick();
    end
    for (int t = 0; t < 40 && busy; t++) tick();
    chk("rand_drain_busy", busy, 1'b0);

    tick();
    tick();
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
